// File: rtl/reset_sequencer.sv
// Staggered multi-channel power-on reset sequencer with deassert synchroniser and done flag.
// Optional soft-reset request input is enabled by defining SOFT_RST_EN.
module reset_sequencer #(
  parameter int unsigned               NUM_CH = 3,
  parameter int unsigned               CNT_W  = 32,
  parameter logic [NUM_CH*CNT_W-1:0]   THRESH = {32'h011FFFFF, 32'h002FFFFF, 32'h001FFFFF},
  parameter logic [CNT_W-1:0]          TERM   = 32'h011FFFFF
) (
  input  logic              iCLK,
  input  logic              iRST,
`ifdef SOFT_RST_EN
  input  logic              iSOFT_RST,
`endif
  output logic [NUM_CH-1:0] oRST,
  output logic              oDONE,
  output logic [CNT_W-1:0]  oCNT
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q, sync_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]  rst_q, rst_d;
  logic               done_q, done_d;
  logic               rst_sync;
  logic               soft_req;

  assign rst_sync = sync_q[1];

`ifdef SOFT_RST_EN
  assign soft_req = iSOFT_RST;
`else
  assign soft_req = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sync_q  <= 2'b00;
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  // Leaving HOLD on the edge that raises rst_sync lets counting start on the very next edge.
  always_comb begin
    sync_d  = {sync_q[0], 1'b1};
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    done_d  = done_q;

    case (state_q)
      HOLD: begin
        cnt_d  = '0;
        rst_d  = '0;
        done_d = 1'b0;
        if (sync_q[0] && !soft_req) state_d = RUN;
      end
      RUN: begin
        if (rst_sync) begin
          if (cnt_q != TERM) cnt_d = cnt_q + CNT_W'(1);
          for (int k = 0; k < NUM_CH; k++) begin
            if (cnt_q >= THRESH[k*CNT_W +: CNT_W]) rst_d[k] = 1'b1;
          end
          if (cnt_q == TERM) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        cnt_d  = TERM;
        rst_d  = '1;
        done_d = 1'b1;
      end
      default: state_d = HOLD;
    endcase

    if (soft_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end
  end

  assign oRST  = rst_q;
  assign oDONE = done_q;
  assign oCNT  = cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: two instances (staggered and equal/zero thresholds) share clock and resets.
// Soft-reset scenarios are exercised when SOFT_RST_EN is defined.
module tb_reset_sequencer;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic       softReq = 1'b0;
  logic [2:0] rstA, rstB;
  logic       doneA, doneB;
  logic [7:0] cntA, cntB;

  int edgeNo = 0;
  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    int         edgeIdx;
    logic [2:0] rstA;
    logic       doneA;
    logic [7:0] cntA;
    logic [2:0] rstB;
    logic       doneB;
    logic [7:0] cntB;
    string      tag;
  } exp_t;

  exp_t scoreQ[$];

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) edgeNo <= edgeNo + 1;

  reset_sequencer #(
    .NUM_CH(3), .CNT_W(8),
    .THRESH({8'd20, 8'd10, 8'd5}),
    .TERM(8'd20)
  ) dutA (
    .iCLK(iCLK),
    .iRST(iRST),
`ifdef SOFT_RST_EN
    .iSOFT_RST(softReq),
`endif
    .oRST(rstA),
    .oDONE(doneA),
    .oCNT(cntA)
  );

  reset_sequencer #(
    .NUM_CH(3), .CNT_W(8),
    .THRESH({8'd3, 8'd3, 8'd0}),
    .TERM(8'd3)
  ) dutB (
    .iCLK(iCLK),
    .iRST(iRST),
`ifdef SOFT_RST_EN
    .iSOFT_RST(softReq),
`endif
    .oRST(rstB),
    .oDONE(doneB),
    .oCNT(cntB)
  );

  // Edge e after a release: counting starts after `off` edges, each channel rises on edge th+off+1.
  function automatic logic [7:0] modelCnt(input int e, input int off, input int term);
    if (e <= off) return 8'd0;
    if (e - off > term) return 8'(term);
    return 8'(e - off);
  endfunction

  function automatic exp_t model(input int absEdge, input int e, input int off, input string tag);
    exp_t x;
    x.edgeIdx = absEdge;
    x.tag     = tag;
    if (off < 0) begin
      x.rstA = 3'b000; x.doneA = 1'b0; x.cntA = 8'd0;
      x.rstB = 3'b000; x.doneB = 1'b0; x.cntB = 8'd0;
    end else begin
      x.rstA  = {e >= 20 + off + 1, e >= 10 + off + 1, e >= 5 + off + 1};
      x.doneA = (e >= 20 + off + 1);
      x.cntA  = modelCnt(e, off, 20);
      x.rstB  = {e >= 3 + off + 1, e >= 3 + off + 1, e >= 0 + off + 1};
      x.doneB = (e >= 3 + off + 1);
      x.cntB  = modelCnt(e, off, 3);
    end
    return x;
  endfunction

  task automatic pushRun(input int n, input int off, input string tag);
    int base;
    base = edgeNo;
    for (int e = 1; e <= n; e++) scoreQ.push_back(model(base + e, e, off, tag));
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge iCLK);
    @(negedge iCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s at edge %0d: got %0h, required %0h", name, idx, act, req);
    end
  endtask

  // Monitor: every negedge, pop and compare the expectations due on the edge just taken.
  always @(negedge iCLK) begin : monitor
    exp_t x;
    while (scoreQ.size() > 0 && scoreQ[0].edgeIdx <= edgeNo) begin
      x = scoreQ.pop_front();
      if (x.edgeIdx != edgeNo) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL stale %s: due edge %0d, seen at %0d", x.tag, x.edgeIdx, edgeNo);
      end else begin
        checkOutput({x.tag, ".rstA"},  x.edgeIdx, 8'(rstA),  8'(x.rstA));
        checkOutput({x.tag, ".doneA"}, x.edgeIdx, 8'(doneA), 8'(x.doneA));
        checkOutput({x.tag, ".cntA"},  x.edgeIdx, cntA,      x.cntA);
        checkOutput({x.tag, ".rstB"},  x.edgeIdx, 8'(rstB),  8'(x.rstB));
        checkOutput({x.tag, ".doneB"}, x.edgeIdx, 8'(doneB), 8'(x.doneB));
        checkOutput({x.tag, ".cntB"},  x.edgeIdx, cntB,      x.cntB);
      end
    end
  end

  initial begin
    // Power-on: reset held low for five edges, then a full run plus 300 saturated edges.
    iRST = 1'b0;
    softReq = 1'b0;
    pushRun(5, -1, "powerHold");
    applyStimulus(5);
    iRST = 1'b1;
    $display("[TB] power-on release and saturation run");
    pushRun(330, 2, "powerOn");
    applyStimulus(330);

    // Reset drop between edges 14 and 15 must clear outputs before edge 15.
    iRST = 1'b0;
    pushRun(3, -1, "preRerun");
    applyStimulus(3);
    iRST = 1'b1;
    pushRun(13, 2, "rerun");
    applyStimulus(13);
    scoreQ.push_back(model(edgeNo + 1, 0, -1, "asyncDrop"));
    @(posedge iCLK);
    #2;
    iRST = 1'b0;
    @(negedge iCLK);
    #1;
    pushRun(3, -1, "holdLow");
    applyStimulus(3);
    iRST = 1'b1;
    $display("[TB] re-release after asynchronous drop");
    pushRun(30, 2, "rerelease");
    applyStimulus(30);

`ifdef SOFT_RST_EN
    // Soft reset pulse from DONE: four high edges, then a restart with no synchroniser delay.
    softReq = 1'b1;
    pushRun(4, -1, "softHigh");
    applyStimulus(4);
    softReq = 1'b0;
    $display("[TB] soft reset restart");
    pushRun(30, 1, "softRun");
    applyStimulus(30);

    // Soft reset toggling while board reset is held must have no effect.
    iRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      softReq = 1'b1;
      pushRun(1, -1, "softInReset");
      applyStimulus(1);
      softReq = 1'b0;
      pushRun(1, -1, "softInReset");
      applyStimulus(1);
    end
    iRST = 1'b1;
    pushRun(30, 2, "afterSoftInReset");
    applyStimulus(30);
`endif

    applyStimulus(1);
    assertCount++;
    if (scoreQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL queueDrain: %0d entries left, required 0", scoreQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised multi-channel power-on reset sequencer for the camera/SDRAM/VGA datapath.
- Releases NUM_CH downstream reset lines in a staggered order, each at its own programmable count after board reset.
- Adds three things the fixed three-output delay block lacks: a reset-deassert synchroniser, a terminal-count done flag, and a synchronous soft-reset request that re-runs the whole sequence.

Parameters:
- NUM_CH, 3: number of sequenced reset outputs (1..16).
- CNT_W, 32: counter width in bits.
- THRESH, {32'h011FFFFF, 32'h002FFFFF, 32'h001FFFFF}: packed NUM_CH*CNT_W release counts; slice k is THRESH[k*CNT_W +: CNT_W] for channel k.
- TERM, 32'h011FFFFF: terminal count at which the counter saturates. Must be >= every THRESH slice.

Ports:
- iCLK, input, 1: system clock; all logic on its rising edge.
- iRST, input, 1: board reset, asynchronous, active-low.
- iSOFT_RST, input, 1: synchronous active-high soft reset request. Present only with SOFT_RST_EN.
- oRST, output, NUM_CH: per-channel release. 0 = hold downstream in reset, 1 = released.
- oDONE, output, 1: high once the counter is at TERM and all channels are released.
- oCNT, output, CNT_W: current counter value, for debug/LEDs.

Behaviour:
- Reset is asynchronous and active-low on iRST. While iRST=0: sync flops=0, Cont=0, oRST=0, oDONE=0, state=HOLD, all immediately (asynchronously).
- Deassert synchroniser: two flops, async-cleared by iRST, D of first flop tied to 1. Internal rst_sync goes high on the 2nd rising edge after iRST rises.
- State HOLD: Cont=0, oRST=0, oDONE=0.
  - HOLD -> RUN on the edge where rst_sync=1 (and iSOFT_RST=0 when the feature is present).
- State RUN, each edge:
  - if Cont != TERM, Cont <= Cont+1;
  - for every k, if the pre-edge Cont >= THRESH[k], oRST[k] <= 1 (sticky until HOLD);
  - if the pre-edge Cont == TERM, state <= DONE and oDONE <= 1.
- State DONE: Cont held at TERM, oRST all 1, oDONE=1. DONE is stable until iRST or soft reset.
- Release timing: oRST[k] rises on the (THRESH[k]+3)th rising edge after iRST deasserts, counting edge 1 as the first edge after the release. This is 2 synchroniser edges plus THRESH[k]+1 count edges.
- oDONE rises on edge TERM+3 after iRST deasserts.
- Release order follows THRESH values, not channel index. Channels with equal THRESH release on the same edge.
- THRESH[k]=0: the channel releases on edge 3.
- Counter never wraps. It saturates at TERM, so a CNT_W-bit all-ones TERM is legal.
- iRST asserted mid-sequence or in DONE: all outputs drop asynchronously and the sequence restarts from the synchroniser.
- oCNT = Cont, registered, with no extra latency.

Optional Feature:
- Macro: SOFT_RST_EN.
- Defined:
  - iSOFT_RST port exists. iSOFT_RST=1 sampled at an edge in RUN or DONE forces the next state to HOLD: Cont=0, oRST=0, oDONE=0 on that edge.
  - The block stays in HOLD while iSOFT_RST=1.
  - On the first edge with iSOFT_RST=0 it enters RUN. oRST[k] then rises on the (THRESH[k]+2)th edge after iSOFT_RST falls; no synchroniser delay applies.
  - iSOFT_RST is ignored while iRST=0.
- Not defined: no iSOFT_RST port; HOLD is left only through rst_sync.

Test Plan (bench parameters: NUM_CH=3, CNT_W=8, THRESH={8'd20,8'd10,8'd5}, TERM=8'd20):
- Power-on: iRST low 5 cycles, then high. Required: oRST=3'b000 through edge 7; oRST[0]=1 at edge 8; oRST[1]=1 at edge 13; oRST[2]=1 and oDONE=1 at edge 23; oCNT stays at 20 thereafter.
- Async reset mid-run: drop iRST between edges 14 and 15. Required: oRST=0, oDONE=0, oCNT=0 before edge 15 with no clock needed; after re-release, the first test's timing repeats exactly.
- Saturation: run 300 cycles past DONE. Required: oCNT=20 constant, oRST=3'b111, oDONE=1, no wrap.
- Unordered/equal thresholds: THRESH={8'd3,8'd3,8'd0}, TERM=3. Required: oRST[0]=1 at edge 3; oRST[2:1]=2'b11 at edge 6; oDONE=1 at edge 6.
- SOFT_RST_EN: in DONE, pulse iSOFT_RST high for 4 cycles. Required: oRST=0 and oDONE=0 on the first sampling edge; oRST[0]=1 at edge 7 after the fall; oRST[1]=1 at edge 12; oDONE=1 at edge 22.
- SOFT_RST_EN with iRST=0: toggle iSOFT_RST. Required: outputs stay 0, and the power-on timing is unchanged after iRST rises.
